// File: rtl/relu_forward_if.sv
// Control (go/done) and source/destination memory request/done handshake bundle for relu_forward.
// master: the activation stage; slave: the controller plus memory side that serves it.
interface relu_forward_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              go;
  logic              done;
  logic [ADDR_W-1:0] src_region_begin;
  logic [ADDR_W-1:0] src_ptr;
  logic              src_r_en;
  logic              src_avail;
  logic              src_done;
  logic [DATA_W-1:0] src_data_load;
  logic [ADDR_W-1:0] dst_region_begin;
  logic [ADDR_W-1:0] dst_ptr;
  logic              dst_w_en;
  logic              dst_avail;
  logic              dst_done;
  logic [DATA_W-1:0] dst_data_store;

  modport master (
    input  go, src_region_begin, src_done, src_data_load, dst_region_begin, dst_done,
    output done, src_ptr, src_r_en, src_avail, dst_ptr, dst_w_en, dst_avail, dst_data_store
  );

  modport slave (
    output go, src_region_begin, src_done, src_data_load, dst_region_begin, dst_done,
    input  done, src_ptr, src_r_en, src_avail, dst_ptr, dst_w_en, dst_avail, dst_data_store
  );
endinterface

// File: rtl/relu_forward.sv
// Element-wise ReLU over a {rows, cols, data...} tensor, copying the header to the destination.
// Define RELU_LEAKY_EN to scale negative elements by 2^-LEAK_SHIFT instead of clamping them to zero.
module relu_forward #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int CNT_W      = 32,
  parameter int LEAK_SHIFT = 3
) (
  input  logic         clk,
  input  logic         rst,
  relu_forward_if.master bus
);

`ifdef RELU_LEAKY_EN
  localparam bit LEAKY = 1'b1;
`else
  localparam bit LEAKY = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};

  typedef enum logic [3:0] {
    S_WAIT = 4'd0,
    S_HR0  = 4'd1,
    S_HW0  = 4'd2,
    S_HR1  = 4'd3,
    S_HW1  = 4'd4,
    S_RD   = 4'd5,
    S_EX   = 4'd6,
    S_WR   = 4'd7,
    S_DONE = 4'd8
  } state_t;

  state_t            state_r;
  logic [ADDR_W-1:0] src_ptr_r;
  logic [ADDR_W-1:0] dst_ptr_r;
  logic              src_r_en_r;
  logic              dst_w_en_r;
  logic              done_r;
  logic [DATA_W-1:0] data_r;
  logic [DATA_W-1:0] x_r;
  logic [DATA_W-1:0] rows_r;
  logic [DATA_W-1:0] cols_r;
  logic [CNT_W-1:0]  count_r;
  logic [CNT_W-1:0]  idx_r;
  logic [CNT_W-1:0]  count_s;
  logic [CNT_W-1:0]  idx_next_s;

  function automatic logic [DATA_W-1:0] activate(input logic [DATA_W-1:0] x);
    logic [DATA_W-1:0] y;
    if (!x[DATA_W-1]) begin
      y = x;
    end else if (LEAKY) begin
      y = $unsigned($signed(x) >>> LEAK_SHIFT);
    end else begin
      y = {DATA_W{1'b0}};
    end
    return y;
  endfunction

  // Element count is taken modulo 2^CNT_W, so truncating the operands first is equivalent.
  assign count_s    = CNT_W'(rows_r) * CNT_W'(cols_r);
  assign idx_next_s = idx_r + CNT_ONE;

  // Sequencer: each request state spends one cycle with the request low, then holds it until done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= S_WAIT;
      src_ptr_r  <= {ADDR_W{1'b0}};
      dst_ptr_r  <= {ADDR_W{1'b0}};
      src_r_en_r <= 1'b0;
      dst_w_en_r <= 1'b0;
      done_r     <= 1'b0;
      data_r     <= {DATA_W{1'b0}};
      x_r        <= {DATA_W{1'b0}};
      rows_r     <= {DATA_W{1'b0}};
      cols_r     <= {DATA_W{1'b0}};
      count_r    <= CNT_ZERO;
      idx_r      <= CNT_ZERO;
    end else begin
      case (state_r)
        S_WAIT: begin
          if (bus.go) begin
            src_ptr_r <= bus.src_region_begin;
            dst_ptr_r <= bus.dst_region_begin;
            state_r   <= S_HR0;
          end
        end
        S_HR0: begin
          if (!src_r_en_r) begin
            src_r_en_r <= 1'b1;
          end else if (bus.src_done) begin
            rows_r     <= bus.src_data_load;
            data_r     <= bus.src_data_load;
            src_r_en_r <= 1'b0;
            src_ptr_r  <= src_ptr_r + ADDR_ONE;
            state_r    <= S_HW0;
          end
        end
        S_HW0: begin
          if (!dst_w_en_r) begin
            dst_w_en_r <= 1'b1;
          end else if (bus.dst_done) begin
            dst_w_en_r <= 1'b0;
            dst_ptr_r  <= dst_ptr_r + ADDR_ONE;
            state_r    <= S_HR1;
          end
        end
        S_HR1: begin
          if (!src_r_en_r) begin
            src_r_en_r <= 1'b1;
          end else if (bus.src_done) begin
            cols_r     <= bus.src_data_load;
            data_r     <= bus.src_data_load;
            src_r_en_r <= 1'b0;
            src_ptr_r  <= src_ptr_r + ADDR_ONE;
            state_r    <= S_HW1;
          end
        end
        S_HW1: begin
          if (!dst_w_en_r) begin
            dst_w_en_r <= 1'b1;
          end else if (bus.dst_done) begin
            dst_w_en_r <= 1'b0;
            dst_ptr_r  <= dst_ptr_r + ADDR_ONE;
            count_r    <= count_s;
            idx_r      <= CNT_ZERO;
            if (count_s == CNT_ZERO) begin
              done_r  <= 1'b1;
              state_r <= S_DONE;
            end else begin
              state_r <= S_RD;
            end
          end
        end
        S_RD: begin
          if (!src_r_en_r) begin
            src_r_en_r <= 1'b1;
          end else if (bus.src_done) begin
            x_r        <= bus.src_data_load;
            src_r_en_r <= 1'b0;
            src_ptr_r  <= src_ptr_r + ADDR_ONE;
            state_r    <= S_EX;
          end
        end
        S_EX: begin
          data_r  <= activate(x_r);
          state_r <= S_WR;
        end
        S_WR: begin
          if (!dst_w_en_r) begin
            dst_w_en_r <= 1'b1;
          end else if (bus.dst_done) begin
            dst_w_en_r <= 1'b0;
            dst_ptr_r  <= dst_ptr_r + ADDR_ONE;
            idx_r      <= idx_next_s;
            if (idx_next_s == count_r) begin
              done_r  <= 1'b1;
              state_r <= S_DONE;
            end else begin
              state_r <= S_RD;
            end
          end
        end
        S_DONE: begin
          if (!bus.go) begin
            done_r  <= 1'b0;
            state_r <= S_WAIT;
          end
        end
        default: begin
          src_r_en_r <= 1'b0;
          dst_w_en_r <= 1'b0;
          done_r     <= 1'b0;
          state_r    <= S_WAIT;
        end
      endcase
    end
  end

  assign bus.done           = done_r;
  assign bus.src_ptr        = src_ptr_r;
  assign bus.src_r_en       = src_r_en_r;
  assign bus.src_avail      = src_r_en_r;
  assign bus.dst_ptr        = dst_ptr_r;
  assign bus.dst_w_en       = dst_w_en_r;
  assign bus.dst_avail      = dst_w_en_r;
  assign bus.dst_data_store = data_r;

endmodule

// File: tb/tb_relu_forward.sv
// Directed bench for relu_forward: header copy, mixed signs, empty tensor, stalls, mid-run reset, go/done.
module tb_relu_forward;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  relu_forward_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  relu_forward #(.DATA_W(32), .ADDR_W(32), .CNT_W(32), .LEAK_SHIFT(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef RELU_LEAKY_EN
  localparam logic [31:0] Y_M1  = 32'hFFFF_FFFF;
  localparam logic [31:0] Y_M2  = 32'hFFFF_FFFF;
  localparam logic [31:0] Y_M4  = 32'hFFFF_FFFF;
  localparam logic [31:0] Y_M6  = 32'hFFFF_FFFF;
  localparam logic [31:0] Y_M7  = 32'hFFFF_FFFF;
  localparam logic [31:0] Y_MIN = 32'hF000_0000;
  localparam logic [31:0] Y_M64 = 32'hFFFF_FFF8;
`else
  localparam logic [31:0] Y_M1  = 32'h0;
  localparam logic [31:0] Y_M2  = 32'h0;
  localparam logic [31:0] Y_M4  = 32'h0;
  localparam logic [31:0] Y_M6  = 32'h0;
  localparam logic [31:0] Y_M7  = 32'h0;
  localparam logic [31:0] Y_MIN = 32'h0;
  localparam logic [31:0] Y_M64 = 32'h0;
`endif

  localparam int SRC_A = 16;
  localparam int SRC_B = 48;
  localparam int DST   = 64;

  logic [31:0] mem [0:127];
  int n_cmp = 0;
  int n_err = 0;
  int n_rd = 0;
  int n_wr = 0;
  int max_stall = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_src(input int base, input logic [31:0] w [0:7]);
    for (int i = 0; i < 8; i++) mem[base + i] = w[i];
    for (int i = 0; i < 16; i++) mem[DST + i] = 32'hDEAD_BEEF;
  endtask

  task automatic check_region(input string tag, input int n, input logic [31:0] w [0:7]);
    for (int i = 0; i < n; i++) check($sformatf("%s[%0d]", tag, i), mem[DST + i], w[i]);
  endtask

  task automatic run_op(input string tag, input bit drop_go_early);
    bit seen;
    seen = 1'b0;
    n_rd = 0;
    n_wr = 0;
    bus.go = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (drop_go_early && c == 3) bus.go = 1'b0;
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
  endtask

  task automatic end_op(input string tag);
    bus.go = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check({tag, "_done_cleared"}, {31'd0, bus.done}, 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_done"}, {31'd0, bus.done}, 32'd0);
    check({tag, "_src_r_en"}, {31'd0, bus.src_r_en}, 32'd0);
    check({tag, "_src_avail"}, {31'd0, bus.src_avail}, 32'd0);
    check({tag, "_dst_w_en"}, {31'd0, bus.dst_w_en}, 32'd0);
    check({tag, "_dst_avail"}, {31'd0, bus.dst_avail}, 32'd0);
    check({tag, "_src_ptr"}, bus.src_ptr, 32'd0);
    check({tag, "_dst_ptr"}, bus.dst_ptr, 32'd0);
    check({tag, "_data_store"}, bus.dst_data_store, 32'd0);
  endtask

  // Memory model: serves one request per port with a random stall, checking the request stays put.
  initial begin
    int src_wait;
    int dst_wait;
    logic [31:0] src_hold;
    logic [31:0] dst_hold;
    logic [31:0] dat_hold;
    src_wait = -1;
    dst_wait = -1;
    src_hold = 32'd0;
    dst_hold = 32'd0;
    dat_hold = 32'd0;
    bus.src_done = 1'b0;
    bus.dst_done = 1'b0;
    bus.src_data_load = 32'd0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        bus.src_done = 1'b0;
        bus.dst_done = 1'b0;
        src_wait = -1;
        dst_wait = -1;
      end else begin
        if (bus.src_done) begin
          bus.src_done = 1'b0;
        end else if (bus.src_r_en === 1'b1) begin
          check("src_avail", {31'd0, bus.src_avail}, 32'd1);
          if (src_wait < 0) begin
            src_wait = int'($urandom_range(max_stall, 0));
            src_hold = bus.src_ptr;
          end else begin
            check("src_ptr_stable", bus.src_ptr, src_hold);
          end
          if (src_wait == 0) begin
            bus.src_data_load = mem[bus.src_ptr[6:0]];
            bus.src_done = 1'b1;
            n_rd++;
            src_wait = -1;
          end else begin
            src_wait--;
          end
        end
        if (bus.dst_done) begin
          bus.dst_done = 1'b0;
        end else if (bus.dst_w_en === 1'b1) begin
          check("dst_avail", {31'd0, bus.dst_avail}, 32'd1);
          if (dst_wait < 0) begin
            dst_wait = int'($urandom_range(max_stall, 0));
            dst_hold = bus.dst_ptr;
            dat_hold = bus.dst_data_store;
          end else begin
            check("dst_ptr_stable", bus.dst_ptr, dst_hold);
            check("dst_data_stable", bus.dst_data_store, dat_hold);
          end
          if (dst_wait == 0) begin
            mem[bus.dst_ptr[6:0]] = bus.dst_data_store;
            bus.dst_done = 1'b1;
            n_wr++;
            dst_wait = -1;
          end else begin
            dst_wait--;
          end
        end
      end
    end
  end

  // Watchdog in case the sequence below never reaches its summary.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Directed test sequence.
  initial begin
    logic [31:0] v [0:7];
    logic [31:0] e [0:7];
    bit hit;

    rst = 1'b1;
    bus.go = 1'b0;
    bus.src_region_begin = SRC_A;
    bus.dst_region_begin = DST;
    #1;
    check_idle_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Header pass-through, 2x3 with alternating signs.
    v = '{32'd2, 32'd3, 32'd1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFC, 32'd5, 32'hFFFF_FFFA};
    e = '{32'd2, 32'd3, 32'd1, Y_M2, 32'd3, Y_M4, 32'd5, Y_M6};
    load_src(SRC_A, v);
    run_op("hdr", 1'b0);
    check("hdr_elem_writes", n_wr - 2, 32'd6);
    check("hdr_reads", n_rd, 32'd8);
    check_region("hdr_dst", 8, e);
    end_op("hdr");

    // Mixed signs and extremes, zero-stall memory.
    v = '{32'd2, 32'd3, 32'd5, 32'hFFFF_FFF9, 32'd0, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFC0};
    e = '{32'd2, 32'd3, 32'd5, Y_M7, 32'd0, 32'h7FFF_FFFF, Y_MIN, Y_M64};
    load_src(SRC_A, v);
    run_op("mix", 1'b0);
    check_region("mix_dst", 8, e);
    end_op("mix");

    // Same tensor with stalls, go dropped early (must still run to completion).
    max_stall = 5;
    load_src(SRC_A, v);
    run_op("stall", 1'b1);
    check("stall_writes", n_wr, 32'd8);
    check_region("stall_dst", 8, e);
    end_op("stall");
    max_stall = 0;

    // Empty tensor: header only.
    v = '{32'd0, 32'd4, 32'd11, 32'd12, 32'd13, 32'd14, 32'd0, 32'd0};
    e = '{32'd0, 32'd4, 32'hDEAD_BEEF, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    load_src(SRC_A, v);
    run_op("empty", 1'b0);
    check("empty_reads", n_rd, 32'd2);
    check("empty_writes", n_wr, 32'd2);
    check_region("empty_dst", 3, e);
    end_op("empty");

    // Reset while element 3 is being written, then rerun from the region bases.
    v = '{32'd2, 32'd3, 32'd5, 32'hFFFF_FFF9, 32'd0, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFC0};
    e = '{32'd2, 32'd3, 32'd5, Y_M7, 32'd0, 32'h7FFF_FFFF, Y_MIN, Y_M64};
    load_src(SRC_A, v);
    hit = 1'b0;
    bus.go = 1'b1;
    for (int c = 0; c < 500; c++) begin
      @(posedge clk);
      #2;
      if (bus.dst_w_en === 1'b1 && bus.dst_ptr === 32'(DST + 4)) begin
        hit = 1'b1;
        break;
      end
    end
    check("rst_reached_wr3", {31'd0, hit}, 32'd1);
    bus.go = 1'b0;
    rst = 1'b1;
    #1;
    check_idle_outputs("midrst");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    load_src(SRC_A, v);
    run_op("rerun", 1'b0);
    check_region("rerun_dst", 8, e);
    end_op("rerun");

    // Go held after done, then a second tensor from a different source base.
    v = '{32'd1, 32'd2, 32'hFFFF_FFFF, 32'd9, 32'd0, 32'd0, 32'd0, 32'd0};
    e = '{32'd1, 32'd2, Y_M1, 32'd9, 32'd0, 32'd0, 32'd0, 32'd0};
    bus.src_region_begin = SRC_B;
    load_src(SRC_B, v);
    run_op("hold", 1'b0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("hold_done", {31'd0, bus.done}, 32'd1);
      check("hold_no_req", {30'd0, bus.src_r_en, bus.dst_w_en}, 32'd0);
    end
    bus.go = 1'b0;
    @(negedge clk);
    check("hold_drop_wait", {31'd0, bus.done}, 32'd0);
    check_region("hold_dst", 4, e);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/relu_forward.md
Name: relu_forward

Overview:
- Activation stage directly downstream of the linear forward stage.
- Reads the linear stage's output tensor from memory and applies ReLU element-wise, y = max(0, x).
- Writes the result tensor, header included, to a destination region. The next layer or the backward pass consumes that region.
- Control uses the same go/done handshake as other compute stages. Memory access uses the same request/done handshake as the mem_handle port set, split into discrete signals.

Parameters:
DATA_W, 32, element/word width; elements are two's-complement integers
ADDR_W, 32, memory pointer width
CNT_W, 32, element counter width; must hold rows*cols
LEAK_SHIFT, 3, negative-slope shift; used only with the optional feature

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
go  in  1  start; level-sensitive, held high until done is observed
done  out  1  high while in DONE
src_region_begin  in  ADDR_W  base address of source tensor (header word 0)
src_ptr  out  ADDR_W  source read address
src_r_en  out  1  source read request
src_avail  out  1  source request valid; same value as src_r_en
src_done  in  1  one-cycle pulse; src_data_load is valid in that cycle
src_data_load  in  DATA_W  source read data
dst_region_begin  in  ADDR_W  base address of destination tensor
dst_ptr  out  ADDR_W  destination write address
dst_w_en  out  1  destination write request
dst_avail  out  1  destination request valid; same value as dst_w_en
dst_done  in  1  one-cycle pulse acknowledging the write
dst_data_store  out  DATA_W  write data

Behaviour:
- Tensor layout: word0 = rows, word1 = cols, then rows*cols elements in row-major order.
- Reset (asynchronous, any state, including mid-transfer):
  - state returns to WAIT;
  - all outputs are 0, and done=0;
  - the element counter, the element count and the held header values are cleared.
- Memory handshake:
  - The block asserts r_en/avail (or w_en/avail) with ptr and data_store held stable until done=1.
  - In the done cycle the block registers the data, and on the next edge it drops the request.
  - The requester never issues more than one outstanding request per port.
  - A done pulse that arrives while no request is pending is ignored.
- States:
  - WAIT: if go, load src_ptr=src_region_begin and dst_ptr=dst_region_begin, then go to HR0.
  - HR0: read word0 and store it as rows. On src_done, src_ptr+1 and go to HW0.
  - HW0: write rows. On dst_done, dst_ptr+1 and go to HR1.
  - HR1: read word1 and store it as cols. On src_done, src_ptr+1 and go to HW1.
  - HW1: write cols. On dst_done, dst_ptr+1 and set count=rows*cols (truncated to CNT_W) and idx=0.
    - If count==0, go to DONE; otherwise go to RD.
  - RD: read element. On src_done, latch x, src_ptr+1 and go to EX.
  - EX (1 cycle): y = x[DATA_W-1] ? 0 : x; go to WR.
  - WR: write y. On dst_done, dst_ptr+1 and idx+1.
    - If idx+1==count, go to DONE; otherwise go to RD.
  - DONE: done=1. Stay while go=1; go to WAIT when go=0.
- Latency per element with 0-wait memory (done in the first request cycle): 1 RD + 1 drop + 1 EX + 1 WR + 1 drop = 5 cycles.
  - Total = 4 header cycles*2 + 5*count + 1 (approx.). Benches check ordering and values, not exact cycle counts.
- Boundaries:
  - x = most negative value gives y=0.
  - x=0 gives y=0.
  - x = most positive value passes through unchanged.
  - rows or cols = 0 writes the header only; no element traffic.
- src and dst regions must not overlap, except when exactly equal (in-place operation is legal because each element is read before it is written).
- go deasserted mid-operation is ignored; the operation runs to DONE.

Optional Feature:
- Macro RELU_LEAKY_EN.
- Defined: EX computes y = x[DATA_W-1] ? (x >>> LEAK_SHIFT) : x (arithmetic shift, sign preserved).
- Undefined: plain ReLU, and LEAK_SHIFT is unused.
- Handshakes and timing are identical in both builds.

Test Plan:
- Header pass-through: src = {2,3,...}, go=1 → dst words 0,1 = 2,3; done rises after exactly 6 element writes.
- Mixed signs: 2x2 elements {5, -7, 0, 0x7FFFFFFF} → dst = {5, 0, 0, 0x7FFFFFFF}. With RELU_LEAKY_EN and LEAK_SHIFT=3, -7 → -1 and -64 → -8.
- Empty tensor: rows=0, cols=4 → only 2 header writes, no element reads, done asserts.
- Memory stalls: random 0–5 cycle delay on src_done/dst_done → ptr, data_store and request held stable while waiting; results match the zero-stall run.
- Reset mid-operation: assert rst during WR of element 3 → all outputs 0 immediately; after release and go, the full tensor is reprocessed correctly from the region bases.
- Done/go handshake: hold go high 10 cycles after done → stays in DONE with no memory requests; drop go → WAIT next cycle; a second go runs a second tensor.
